// File: rtl/xor_gate_pkg.sv
// Shared constants and helpers for the xor_gate block: default operand width,
// transaction counter width and the popcount result width.
package xor_gate_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int COUNT_WIDTH   = 16;

  // Width needed to hold a population count of 0..width inclusive.
  function automatic int hamming_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/xor_gate_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount
  import xor_gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]                vec,
  output logic [hamming_width(WIDTH)-1:0] count
);

  localparam int HW = hamming_width(WIDTH);

  // NOTE: combinational outputs get a default before the loop so no path
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + HW'(vec[i]);
    end
  end

endmodule

// File: rtl/xor_gate.sv
// Bitwise XOR with a combinational result plus a registered result stage that
// also reports hamming distance, parity, equality and a saturating op counter.
module xor_gate
  import xor_gate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  input  logic                            in_valid,
  output logic [WIDTH-1:0]                out,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_q,
  output logic [hamming_width(WIDTH)-1:0] hamming_q,
  output logic                            parity_q,
  output logic                            zero_q,
  output logic [COUNT_WIDTH-1:0]          op_count
);

  localparam int HW = hamming_width(WIDTH);

  logic [HW-1:0] hamming;

  // The live XOR is independent of clock and reset.
  assign out = a ^ b;

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .vec   (out),
    .count (hamming)
  );

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      hamming_q <= '0;
      parity_q  <= 1'b0;
      zero_q    <= 1'b0;
      op_count  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q     <= out;
        hamming_q <= hamming;
        parity_q  <= ^out;
        zero_q    <= (hamming == '0);
        // Saturate rather than wrap once every count value is used.
        if (op_count != '1) begin
          op_count <= op_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_gate.sv
// Directed self-checking bench for xor_gate with a scoreboard of registered results.
module tb_xor_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        in_valid;
  logic [15:0] out;
  logic        out_valid;
  logic [15:0] out_q;
  logic [4:0]  hamming_q;
  logic        parity_q;
  logic        zero_q;
  logic [15:0] op_count;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  hw;
    logic        par;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  int          checks = 0;
  int          errors = 0;
  int          model_count = 0;

  always #5 clk = ~clk;

  xor_gate dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .out_q     (out_q),
    .hamming_q (hamming_q),
    .parity_q  (parity_q),
    .zero_q    (zero_q),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb);
    exp_t e;
    e.res  = ta ^ tb;
    e.hw   = 5'($countones(ta ^ tb));
    e.par  = e.hw[0];
    e.zero = (ta == tb);
    return e;
  endfunction

  // Drive one cycle's inputs, then check the registered stage at the next negedge.
  task automatic cycle(input logic [15:0] ta, input logic [15:0] tb,
                       input logic tv, input logic trst, input bit do_check);
    exp_t e;
    logic exp_valid;
    a = ta; b = tb; in_valid = tv; rst = trst;
    exp_valid = tv && !trst;
    if (trst) begin
      sb.delete();
      model_count = 0;
      last = '{res: '0, hw: '0, par: 1'b0, zero: 1'b0};
    end else if (tv) begin
      sb.push_back(model(ta, tb));
      if (model_count < 16'hFFFF) model_count++;
    end
    #1;
    if (do_check) check("out_comb", 32'(out), 32'(ta ^ tb));
    @(posedge clk);
    @(negedge clk);
    if (!do_check) begin
      if (exp_valid) last = sb.pop_front();
      return;
    end
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        last = sb.pop_front();
      end
    end
    check("out_q",     32'(out_q),     32'(last.res));
    check("hamming_q", 32'(hamming_q), 32'(last.hw));
    check("parity_q",  32'(parity_q),  32'(last.par));
    check("zero_q",    32'(zero_q),    32'(last.zero));
    check("op_count",  32'(op_count),  32'(model_count));
  endtask

  initial begin
    a = '0; b = '0; in_valid = 1'b0; rst = 1'b1;
    last = '{res: '0, hw: '0, par: 1'b0, zero: 1'b0};

    // Reset state
    cycle(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    cycle(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1);

    // Combinational vectors, no transaction
    cycle(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle(16'h000E, 16'h0015, 1'b0, 1'b0, 1'b1);
    cycle(16'h0003, 16'h00DD, 1'b0, 1'b0, 1'b1);
    check("out_const", 32'(out), 32'h00DE);

    // Registered result with fixed expectations
    cycle(16'h000E, 16'h0015, 1'b1, 1'b0, 1'b1);
    check("spec_out_q", 32'(out_q), 32'h001B);
    check("spec_hamming", 32'(hamming_q), 32'd4);
    cycle(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);  // idle: hold

    // Equality
    cycle(16'hA5A5, 16'hA5A5, 1'b1, 1'b0, 1'b1);
    check("spec_zero", 32'(zero_q), 32'd1);

    // Extremes
    cycle(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    check("spec_hamming_max", 32'(hamming_q), 32'd16);
    cycle(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    check("spec_parity_odd", 32'(parity_q), 32'd1);

    // Reset priority over a valid transaction; out still live
    cycle(16'h5A5A, 16'h0F0F, 1'b1, 1'b1, 1'b1);
    check("rst_prio_out", 32'(out), 32'h5555);

    // Three back-to-back transactions then idle
    cycle(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1);
    cycle(16'hF0F0, 16'h0FF0, 1'b1, 1'b0, 1'b1);
    cycle(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
    cycle(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("count3", 32'(op_count), 32'd3);

    // Reset while out_valid is high
    cycle(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b1);
    cycle(16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Drive the counter to saturation
    for (int i = 0; i < 65533; i++) begin
      cycle(16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0);
    end
    cycle(16'h3C3C, 16'hC3C3, 1'b1, 1'b0, 1'b1);
    check("count_fffe", 32'(op_count), 32'hFFFE);
    cycle(16'h0001, 16'h0003, 1'b1, 1'b0, 1'b1);
    check("count_ffff", 32'(op_count), 32'hFFFF);
    cycle(16'h7777, 16'h1111, 1'b1, 1'b0, 1'b1);
    check("count_sat", 32'(op_count), 32'hFFFF);
    cycle(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
